// File: rtl/vga_pkg.sv
// Shared VGA constants: mode encodings, default timing window and the
// 8-colour foreground palette used by the pattern generator.
package vga_pkg;

   localparam logic [1:0] MODE_SOLID   = 2'd0;
   localparam logic [1:0] MODE_BARS    = 2'd1;
   localparam logic [1:0] MODE_CHECKER = 2'd2;
   localparam logic [1:0] MODE_BOX     = 2'd3;

   localparam int H_START_DEF  = 144;
   localparam int H_END_DEF    = 784;
   localparam int V_START_DEF  = 35;
   localparam int V_END_DEF    = 515;
   localparam int BOX_SIZE_DEF = 32;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Full 8-bit palette; every index decodes to its own colour.
   function automatic rgb_t palette(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = '{8'hFF, 8'h00, 8'h00};
         3'd1:    c = '{8'h00, 8'hFF, 8'h00};
         3'd2:    c = '{8'h00, 8'h00, 8'hFF};
         3'd3:    c = '{8'hFF, 8'hFF, 8'h00};
         3'd4:    c = '{8'h89, 8'hCF, 8'hF0};
         3'd5:    c = '{8'hFF, 8'hC0, 8'hCB};
         3'd6:    c = '{8'hFF, 8'hFF, 8'hFF};
         default: c = '{8'h00, 8'h00, 8'h00};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/box_mover.sv
// One axis of the bouncing box: position walks 0..MAX_POS and reverses at
// each end. Advances by one step whenever step is high.
module box_mover
   import vga_pkg::*;
#(
   parameter int MAX_POS = H_END_DEF - H_START_DEF - BOX_SIZE_DEF,
   parameter int W       = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step,
   output logic [W-1:0] pos
);

   logic [W-1:0] pos_reg;
   logic         dir_reg;   // 1 = increasing

   // Bounce at the ends, otherwise move one pixel in the current direction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_reg <= '0;
         dir_reg <= 1'b1;
      end else if (step) begin
         if (dir_reg && pos_reg == W'(MAX_POS)) begin
            dir_reg <= 1'b0;
            pos_reg <= W'(MAX_POS - 1);
         end else if (!dir_reg && pos_reg == '0) begin
            dir_reg <= 1'b1;
            pos_reg <= W'(1);
         end else if (dir_reg) begin
            pos_reg <= pos_reg + W'(1);
         end else begin
            pos_reg <= pos_reg - W'(1);
         end
      end
   end

   assign pos = pos_reg;

endmodule

// File: rtl/pattern_generator.sv
// Test-pattern source for a VGA sync generator: solid colour, colour bars,
// checkerboard and a bouncing box, with one register stage on the outputs
// and a one-clock frame_tick at each frame origin.
module pattern_generator
   import vga_pkg::*;
#(
   parameter int COLOR_W  = 8,
   parameter int H_START  = H_START_DEF,
   parameter int H_END    = H_END_DEF,
   parameter int V_START  = V_START_DEF,
   parameter int V_END    = V_END_DEF,
   parameter int BOX_SIZE = BOX_SIZE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode,
   input  logic [2:0]         switches,
   input  logic [9:0]         hcount,
   input  logic [9:0]         vcount,
   input  logic               display_pixel,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue,
   output logic               frame_tick
);

   localparam int BAR_W   = (H_END - H_START) / 8;
   localparam int BOX_LOG = $clog2(BOX_SIZE);
   localparam int X_MAX   = H_END - H_START - BOX_SIZE;
   localparam int Y_MAX   = V_END - V_START - BOX_SIZE;

   logic [9:0]         x, y;
   logic [9:0]         bx, by;
   logic               active;
   logic               in_box;
   logic [2:0]         bar_idx;
   rgb_t               fg;
   rgb_t               pix_next;
   logic               origin;
   logic               origin_reg;
   logic               frame_tick_reg;
   logic [COLOR_W-1:0] red_reg, green_reg, blue_reg;

   // 11-bit compares keep the window test correct up to a 1024 limit.
   assign active = ({1'b0, hcount} >= 11'(H_START)) && ({1'b0, hcount} < 11'(H_END)) &&
                   ({1'b0, vcount} >= 11'(V_START)) && ({1'b0, vcount} < 11'(V_END)) &&
                   display_pixel;
   assign x       = hcount - 10'(H_START);
   assign y       = vcount - 10'(V_START);
   assign bar_idx = 3'(x / 10'(BAR_W));
   assign fg      = palette(switches);
   assign in_box  = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < {1'b0, bx} + 11'(BOX_SIZE)) &&
                    ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < {1'b0, by} + 11'(BOX_SIZE));
   assign origin  = (hcount == 10'd0) && (vcount == 10'd0);

   // Pick the 8-bit colour for the current pixel; black outside the window.
   always_comb begin
      pix_next = '0;
      if (active) begin
         case (mode)
            MODE_SOLID:   pix_next = fg;
            MODE_BARS:    pix_next = palette(bar_idx);
            MODE_CHECKER: pix_next = (x[BOX_LOG] ^ y[BOX_LOG]) ? rgb_t'('0) : fg;
            default:      pix_next = in_box ? fg : rgb_t'('0);
         endcase
      end
   end

   // Register the truncated colour and detect the rising edge of the origin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red_reg        <= '0;
         green_reg      <= '0;
         blue_reg       <= '0;
         frame_tick_reg <= 1'b0;
         origin_reg     <= 1'b1;
      end else begin
         red_reg        <= pix_next.r[7 -: COLOR_W];
         green_reg      <= pix_next.g[7 -: COLOR_W];
         blue_reg       <= pix_next.b[7 -: COLOR_W];
         frame_tick_reg <= origin && !origin_reg;
         origin_reg     <= origin;
      end
   end

   box_mover #(.MAX_POS(X_MAX), .W(10)) u_box_x (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (frame_tick_reg),
      .pos   (bx)
   );

   box_mover #(.MAX_POS(Y_MAX), .W(10)) u_box_y (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (frame_tick_reg),
      .pos   (by)
   );

   assign red        = red_reg;
   assign green      = green_reg;
   assign blue       = blue_reg;
   assign frame_tick = frame_tick_reg;

endmodule
